// File: rtl/vmode_pkg.sv
// vmode_pkg: loader states, register map, control bit positions and video timing presets
package vmode_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISABLE,
        S_WRITE,
        S_VERIFY,
        S_ENABLE,
        S_DONE
    } state_t;

    // Timing registers occupy 0..15 (lo/hi byte pairs), control sits at 16
    localparam logic [4:0] ADDR_TIMING_BASE = 5'd0;
    localparam logic [4:0] ADDR_CTRL        = 5'd16;
    localparam logic [3:0] LAST_TIMING_IDX  = 4'd15;

    localparam int CTL_ACTIVE = 0;
    localparam int CTL_HDMI   = 1;
    localparam int CTL_VGA    = 2;
    localparam int CTL_HPOL   = 3;
    localparam int CTL_VPOL   = 4;

    // Field order [7:0]: v_tot-1, v_se, v_ss, v_act, h_tot-1, h_se, h_ss, h_act
    typedef logic [7:0][11:0] preset_t;

    localparam preset_t MODE0 = {12'd524, 12'd492, 12'd490, 12'd480,
                                 12'd799, 12'd752, 12'd656, 12'd640};
    localparam preset_t MODE1 = {12'd627, 12'd605, 12'd601, 12'd600,
                                 12'd1055, 12'd968, 12'd840, 12'd800};
    localparam preset_t MODE2 = {12'd805, 12'd777, 12'd771, 12'd768,
                                 12'd1343, 12'd1184, 12'd1048, 12'd1024};
    localparam preset_t MODE3 = {12'd749, 12'd730, 12'd725, 12'd720,
                                 12'd1649, 12'd1430, 12'd1390, 12'd1280};

    localparam logic [3:0][7:0][11:0] PRESETS = {MODE3, MODE2, MODE1, MODE0};

    // Bit m set means mode m uses positive sync polarity
    localparam logic [3:0] H_POS = 4'b1010;
    localparam logic [3:0] V_POS = 4'b1010;

    function automatic logic [7:0] ctrl_byte(input logic v_pol, input logic h_pol,
                                             input logic [1:0] out_en);
        logic [7:0] b;
        b             = '0;
        b[CTL_ACTIVE] = 1'b1;
        b[CTL_HDMI]   = out_en[0];
        b[CTL_VGA]    = out_en[1];
        b[CTL_HPOL]   = h_pol;
        b[CTL_VPOL]   = v_pol;
        return b;
    endfunction

endpackage

// File: rtl/vmode_if.sv
// vmode_if: internal register bus between the loader (master) and the video registers (slave)
interface vmode_if;
    logic [4:0] o_addr;
    logic [7:0] o_data;
    logic       o_select;
    logic       o_wr_req;
    logic [7:0] i_data_rd;

    modport master (output o_addr, o_data, o_select, o_wr_req, input  i_data_rd);
    modport slave  (input  o_addr, o_data, o_select, o_wr_req, output i_data_rd);
endinterface

// File: rtl/vmode_rom.sv
// vmode_rom: combinational preset lookup giving the expected register byte, sync polarities and mode validity
module vmode_rom
    import vmode_pkg::*;
(
    input  logic [2:0] i_mode,
    input  logic [3:0] i_idx,
    output logic [7:0] o_byte,
    output logic       o_h_pol,
    output logic       o_v_pol,
    output logic       o_valid
);
    logic [11:0] field;

    // Pick the 12-bit field, then its lo byte or zero-padded hi nibble
    always_comb begin
        field   = PRESETS[i_mode[1:0]][i_idx[3:1]];
        o_byte  = i_idx[0] ? {4'b0, field[11:8]} : field[7:0];
        o_h_pol = H_POS[i_mode[1:0]];
        o_v_pol = V_POS[i_mode[1:0]];
        o_valid = ~i_mode[2];
    end
endmodule

// File: rtl/vmode_loader.sv
// vmode_loader: disables video output, writes and reads back a preset timing mode, then re-enables output
module vmode_loader
    import vmode_pkg::*;
#(
    parameter bit         AUTO_LOAD    = 1'b1,
    parameter int         DEFAULT_MODE = 0,
    parameter logic [1:0] OUT_EN       = 2'b11
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [2:0] i_mode_sel,
    input  logic       i_mode_req,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [2:0] o_mode_cur,
    output logic       o_mode_valid,
    vmode_if.master    bus
);
    localparam logic [2:0] DEF_MODE = 3'(DEFAULT_MODE);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       ph_q, ph_d;
    logic [2:0] mode_q, mode_d;
    logic       err_q, err_d;
    logic [2:0] cur_q, cur_d;
    logic       valid_q, valid_d;
    logic       auto_q;

    logic       req;
    logic [2:0] sel;
    logic [2:0] rom_mode;
    logic [7:0] rom_byte;
    logic       rom_h_pol, rom_v_pol, rom_valid;

    // The first cycle after reset release acts as a request for the default mode
    assign req      = i_mode_req | auto_q;
    assign sel      = auto_q ? DEF_MODE : i_mode_sel;
    // In IDLE the ROM validates the incoming selection, otherwise it serves the latched mode
    assign rom_mode = (state_q == S_IDLE) ? sel : mode_q;

    vmode_rom u_rom (
        .i_mode  (rom_mode),
        .i_idx   (idx_q),
        .o_byte  (rom_byte),
        .o_h_pol (rom_h_pol),
        .o_v_pol (rom_v_pol),
        .o_valid (rom_valid)
    );

    // State and status registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ph_q    <= 1'b0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            cur_q   <= '0;
            valid_q <= 1'b0;
            auto_q  <= AUTO_LOAD;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
            valid_q <= valid_d;
            auto_q  <= 1'b0;
        end
    end

    // Next-state and bus cycle generation; the bus idles at all-zero outside a load
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ph_d         = ph_q;
        mode_d       = mode_q;
        err_d        = 1'b0;
        cur_d        = cur_q;
        valid_d      = valid_q;
        bus.o_select = 1'b0;
        bus.o_wr_req = 1'b0;
        bus.o_addr   = '0;
        bus.o_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (rom_valid) begin
                        state_d = S_DISABLE;
                        mode_d  = sel;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DISABLE: begin
                bus.o_select = 1'b1;
                bus.o_wr_req = 1'b1;
                bus.o_addr   = ADDR_CTRL;
                idx_d        = '0;
                ph_d         = 1'b0;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                bus.o_select = 1'b1;
                bus.o_wr_req = 1'b1;
                bus.o_addr   = ADDR_TIMING_BASE + 5'(idx_q);
                bus.o_data   = rom_byte;
                idx_d        = idx_q + 4'd1;
                if (idx_q == LAST_TIMING_IDX) state_d = S_VERIFY;
            end
            S_VERIFY: begin
                // Phase 0 strobes the read, phase 1 compares the returned byte
                if (!ph_q) begin
                    bus.o_select = 1'b1;
                    bus.o_addr   = ADDR_TIMING_BASE + 5'(idx_q);
                    ph_d         = 1'b1;
                end else begin
                    ph_d  = 1'b0;
                    idx_d = idx_q + 4'd1;
                    if (bus.i_data_rd != rom_byte) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (idx_q == LAST_TIMING_IDX) begin
                        state_d = S_ENABLE;
                    end
                end
            end
            S_ENABLE: begin
                bus.o_select = 1'b1;
                bus.o_wr_req = 1'b1;
                bus.o_addr   = ADDR_CTRL;
                bus.o_data   = ctrl_byte(rom_v_pol, rom_h_pol, OUT_EN);
                cur_d        = mode_q;
                valid_d      = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_err        = err_q;
    assign o_mode_cur   = cur_q;
    assign o_mode_valid = valid_q;

endmodule

// File: tb/tb_vmode_loader.sv
// tb_vmode_loader: directed loads with a queue-based scoreboard checking every bus cycle and status pulse
module tb_vmode_loader;
    localparam int K_BUS  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [4:0] addr;
        logic [7:0] data;
        logic       wr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       busy, done, err, mode_valid;
    logic [2:0] mode_cur;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bad_addr = -1;
    ev_t  q[$];
    logic [7:0] mem [32];

    // Preset timing values (h act, ss, se, tot-1, v act, ss, se, tot-1)
    int pre [4][8] = '{
        '{640, 656, 752, 799, 480, 490, 492, 524},
        '{800, 840, 968, 1055, 600, 601, 605, 627},
        '{1024, 1048, 1184, 1343, 768, 771, 777, 805},
        '{1280, 1390, 1430, 1649, 720, 725, 730, 749}
    };

    vmode_if bus ();

    vmode_loader #(.AUTO_LOAD(1'b1), .DEFAULT_MODE(3), .OUT_EN(2'b11)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_mode_sel   (sel),
        .i_mode_req   (req),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_mode_cur   (mode_cur),
        .o_mode_valid (mode_valid),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model; reads return data one cycle after the strobe, optionally corrupted
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (bus.o_select && bus.o_wr_req) mem[bus.o_addr] <= bus.o_data;
        if (bus.o_select && !bus.o_wr_req)
            bus.i_data_rd <= (int'(bus.o_addr) == bad_addr) ? (mem[bus.o_addr] ^ 8'h01) : mem[bus.o_addr];
        else
            bus.i_data_rd <= 8'h00;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int m, input int k);
        int v;
        v = pre[m][k/2];
        return (k % 2 == 1) ? 8'(v >> 8) : 8'(v & 255);
    endfunction

    function automatic logic [7:0] exp_ctrl(input int m);
        return (m == 1 || m == 3) ? 8'h1F : 8'h07;
    endfunction

    task automatic push(input int kind, input int c, input int a, input int d, input bit w, input int cut);
        ev_t e;
        if (c > cut) return;
        e.kind = kind;
        e.cyc  = c;
        e.addr = 5'(a);
        e.data = 8'(d);
        e.wr   = w;
        q.push_back(e);
    endtask

    // Expected events for a load accepted at the edge ending cycle b; bad = failing readback index; cut = last observed cycle
    task automatic push_load(input int m, input int b, input int bad, input int cut);
        push(K_BUS, b + 1, 16, 0, 1'b1, cut);
        for (int k = 0; k < 16; k++) push(K_BUS, b + 2 + k, k, exp_byte(m, k), 1'b1, cut);
        for (int k = 0; k < 16; k++) begin
            push(K_BUS, b + 18 + 2 * k, k, 0, 1'b0, cut);
            if (k == bad) begin
                push(K_ERR, b + 20 + 2 * k, 0, 0, 1'b0, cut);
                return;
            end
        end
        push(K_BUS, b + 50, 16, exp_ctrl(m), 1'b1, cut);
        push(K_DONE, b + 51, 0, 0, 1'b0, cut);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event kind %0d addr %0d at cycle %0d, required none", kind, bus.o_addr, cyc);
            return;
        end
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind == K_BUS) begin
            chk("bus_addr", int'(bus.o_addr), int'(e.addr));
            chk("bus_wr", int'(bus.o_wr_req), int'(e.wr));
            if (e.wr) chk("bus_data", int'(bus.o_data), int'(e.data));
        end
    endtask

    // Monitor: every strobe or pulse must match the head of the scoreboard queue
    always @(negedge clk) begin
        if (bus.o_select) observe(K_BUS);
        if (done) observe(K_DONE);
        if (err) observe(K_ERR);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic start(input int m);
        sel = 3'(m);
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s timeout: %0d events outstanding, required 0", nm, q.size());
            q.delete();
        end
        repeat (4) step();
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, int'({busy, done, err, mode_valid, mode_cur, bus.o_select, bus.o_wr_req,
                      bus.o_addr, bus.o_data}), 0);
    endtask

    initial begin
        int b;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset_outputs");
        repeat (3) step();

        // Auto-load of DEFAULT_MODE = 3 on reset release
        b = cyc;
        push_load(3, b, -1, 1 << 30);
        rst_n = 1'b1;
        wait_idle("auto_mode3");
        chk("auto_cur", mode_cur, 3);
        chk("auto_valid", mode_valid, 1);

        // Mode 1 full sequence
        b = cyc;
        push_load(1, b, -1, 1 << 30);
        start(1);
        wait_idle("mode1");
        chk("mode1_cur", mode_cur, 1);
        chk("mode1_valid", mode_valid, 1);

        // Invalid mode 5: err in cycle 1, no bus activity, status unchanged
        b = cyc;
        push(K_ERR, b + 1, 0, 0, 1'b0, 1 << 30);
        start(5);
        wait_idle("mode5");
        chk("mode5_cur", mode_cur, 1);
        chk("mode5_valid", mode_valid, 1);

        // Mode 2 with an intruding request at cycle 20
        b = cyc;
        push_load(2, b, -1, 1 << 30);
        start(2);
        to_cycle(b + 20);
        start(0);
        wait_idle("mode2");
        chk("mode2_cur", mode_cur, 2);
        chk("mode2_valid", mode_valid, 1);

        // Mode 0 with corrupted readback at addr 6
        bad_addr = 6;
        b = cyc;
        push_load(0, b, 6, 1 << 30);
        start(0);
        wait_idle("mode0_bad");
        bad_addr = -1;
        chk("bad_cur", mode_cur, 2);
        chk("bad_valid", mode_valid, 0);

        // Request during the DONE cycle is ignored
        b = cyc;
        push_load(1, b, -1, 1 << 30);
        start(1);
        to_cycle(b + 51);
        chk("done_cycle51", done, 1);
        start(3);
        wait_idle("done_req");
        chk("donereq_cur", mode_cur, 1);

        // Reset in cycle 10 of a load, then auto-load of mode 3
        b = cyc;
        push_load(1, b, -1, b + 9);
        start(1);
        to_cycle(b + 10);
        rst_n = 1'b0;
        #1 chk_zero("midload_reset");
        chk("midload_pending", q.size(), 0);
        q.delete();
        repeat (3) step();
        b = cyc;
        push_load(3, b, -1, 1 << 30);
        rst_n = 1'b1;
        wait_idle("reauto_mode3");
        chk("reauto_cur", mode_cur, 3);
        chk("reauto_valid", mode_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
